// File: rtl/dual_issue_inst_queue.sv
// Dual-issue instruction queue between fetch and decode/issue.
// Accepts 0-2 instructions per cycle and presents the head and head+1 entries.
// A branch flush can keep its delay-slot instruction in a dedicated slot
// register, waiting for it to arrive if it has not been fetched yet.
// Optional macro IFIFO_BYPASS_EN: when defined, an empty queue in NORMAL
// presents the write lanes on its outputs in the same cycle.
module dual_issue_inst_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              flush_keep_slot,
    input  logic              write_en1,
    input  logic              write_en2,
    input  logic [DATA_W-1:0] write_data1,
    input  logic [DATA_W-1:0] write_data2,
    input  logic [ADDR_W-1:0] write_address1,
    input  logic [ADDR_W-1:0] write_address2,
    input  logic              read_en1,
    input  logic              read_en2,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [ADDR_W-1:0] address_out1,
    output logic [ADDR_W-1:0] address_out2,
    output logic              valid_out1,
    output logic              valid_out2,
    output logic              delay_slot_out1,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_SLOT      = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   slot_data_q, slot_data_d;
    logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;

    logic [DATA_W-1:0]   mem_data [DEPTH];
    logic [ADDR_W-1:0]   mem_addr [DEPTH];

    logic                mem_we1, mem_we2;
    logic [PTR_W-1:0]    mem_wa1, mem_wa2;
    logic [DATA_W-1:0]   mem_wd1, mem_wd2;
    logic [ADDR_W-1:0]   mem_wpc1, mem_wpc2;

    logic                wr2_req;
    logic [CNT_W-1:0]    wr_n, wr_acc, free_n, rd_req, rd_avail, rd_n;
    logic                wr_ok;
    logic                bypass_c;
    logic [PTR_W-1:0]    head1;

    // Request sizes, capacity check and saturated read count
    assign wr2_req  = write_en1 & write_en2;
    assign wr_n     = CNT_W'(write_en1) + CNT_W'(wr2_req);
    assign free_n   = CNT_W'(DEPTH) - count_q;
    assign wr_ok    = (wr_n <= free_n);
    assign wr_acc   = wr_ok ? wr_n : '0;
    assign rd_req   = CNT_W'(read_en1) + CNT_W'(read_en1 & read_en2);
    assign rd_avail = count_q + (bypass_c ? wr_n : '0);
    assign rd_n     = (rd_req < rd_avail) ? rd_req : rd_avail;
    assign head1    = rd_ptr_q + PTR_W'(1);

`ifdef IFIFO_BYPASS_EN
    assign bypass_c = (state_q == ST_NORMAL) && (count_q == '0);
`else
    assign bypass_c = 1'b0;
`endif

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (free_n < CNT_W'(2));

    // Issue-side view of the head entries, slot register or bypassed writes
    always_comb begin
        valid_out1      = 1'b0;
        valid_out2      = 1'b0;
        delay_slot_out1 = 1'b0;
        data_out1       = '0;
        data_out2       = '0;
        address_out1    = '0;
        address_out2    = '0;
        case (state_q)
            ST_NORMAL: begin
                if (bypass_c) begin
                    valid_out1 = write_en1;
                    valid_out2 = wr2_req;
                    if (write_en1) begin
                        data_out1    = write_data1;
                        address_out1 = write_address1;
                    end
                    if (wr2_req) begin
                        data_out2    = write_data2;
                        address_out2 = write_address2;
                    end
                end else begin
                    valid_out1 = (count_q >= CNT_W'(1));
                    valid_out2 = (count_q >= CNT_W'(2));
                    if (valid_out1) begin
                        data_out1    = mem_data[rd_ptr_q];
                        address_out1 = mem_addr[rd_ptr_q];
                    end
                    if (valid_out2) begin
                        data_out2    = mem_data[head1];
                        address_out2 = mem_addr[head1];
                    end
                end
            end
            ST_SLOT: begin
                valid_out1      = 1'b1;
                delay_slot_out1 = 1'b1;
                data_out1       = slot_data_q;
                address_out1    = slot_addr_q;
            end
            default: ;
        endcase
    end

    // Next-state: flush handling, slot capture and normal enqueue/dequeue
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        slot_data_d = slot_data_q;
        slot_addr_d = slot_addr_q;
        mem_we1     = 1'b0;
        mem_we2     = 1'b0;
        mem_wa1     = wr_ptr_q;
        mem_wa2     = wr_ptr_q + PTR_W'(1);
        mem_wd1     = write_data1;
        mem_wd2     = write_data2;
        mem_wpc1    = write_address1;
        mem_wpc2    = write_address2;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = ST_NORMAL;
            if (flush_keep_slot) begin
                // Second element of {stored entries, write lane 1, write lane 2}
                state_d = ST_WAIT_SLOT;
                if (count_q >= CNT_W'(2)) begin
                    slot_data_d = mem_data[head1];
                    slot_addr_d = mem_addr[head1];
                    state_d     = ST_SLOT;
                end else if (count_q == CNT_W'(1)) begin
                    if (write_en1) begin
                        slot_data_d = write_data1;
                        slot_addr_d = write_address1;
                        state_d     = ST_SLOT;
                    end
                end else if (wr2_req) begin
                    slot_data_d = write_data2;
                    slot_addr_d = write_address2;
                    state_d     = ST_SLOT;
                end
            end
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    mem_we1  = wr_ok & write_en1;
                    mem_we2  = wr_ok & wr2_req;
                    wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
                    rd_ptr_d = rd_ptr_q + PTR_W'(rd_n);
                    count_d  = count_q + wr_acc - rd_n;
                end
                ST_WAIT_SLOT: begin
                    // Lane 1 becomes the delay slot; lane 2 queues behind it
                    if (write_en1) begin
                        slot_data_d = write_data1;
                        slot_addr_d = write_address1;
                        state_d     = ST_SLOT;
                        if (wr2_req) begin
                            mem_we1  = 1'b1;
                            mem_wd1  = write_data2;
                            mem_wpc1 = write_address2;
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                            count_d  = count_q + CNT_W'(1);
                        end
                    end
                end
                ST_SLOT: begin
                    mem_we1  = wr_ok & write_en1;
                    mem_we2  = wr_ok & wr2_req;
                    wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
                    count_d  = count_q + wr_acc;
                    if (read_en1) begin
                        state_d = ST_NORMAL;
                    end
                end
                default: state_d = ST_NORMAL;
            endcase
        end
    end

    // Control state, pointers, occupancy and slot register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_NORMAL;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            slot_data_q <= '0;
            slot_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            slot_data_q <= slot_data_d;
            slot_addr_q <= slot_addr_d;
        end
    end

    // Entry storage; contents are only observed through valid lanes
    always_ff @(posedge clk) begin
        if (mem_we1) begin
            mem_data[mem_wa1] <= mem_wd1;
            mem_addr[mem_wa1] <= mem_wpc1;
        end
        if (mem_we2) begin
            mem_data[mem_wa2] <= mem_wd2;
            mem_addr[mem_wa2] <= mem_wpc2;
        end
    end

endmodule

// File: tb/tb_dual_issue_inst_queue.sv
// Directed bench for dual_issue_inst_queue (DEPTH=16, 32-bit words/PCs).
module tb_dual_issue_inst_queue;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned PTR_W  = 4;

    logic              clk = 1'b0;
    logic              rst, flush, flush_keep_slot;
    logic              write_en1, write_en2, read_en1, read_en2;
    logic [DATA_W-1:0] write_data1, write_data2;
    logic [ADDR_W-1:0] write_address1, write_address2;
    logic [DATA_W-1:0] data_out1, data_out2;
    logic [ADDR_W-1:0] address_out1, address_out2;
    logic              valid_out1, valid_out2, delay_slot_out1;
    logic [PTR_W:0]    count;
    logic              full, empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_issue_inst_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_keep_slot(flush_keep_slot),
        .write_en1(write_en1), .write_en2(write_en2),
        .write_data1(write_data1), .write_data2(write_data2),
        .write_address1(write_address1), .write_address2(write_address2),
        .read_en1(read_en1), .read_en2(read_en2),
        .data_out1(data_out1), .data_out2(data_out2),
        .address_out1(address_out1), .address_out2(address_out2),
        .valid_out1(valid_out1), .valid_out2(valid_out2),
        .delay_slot_out1(delay_slot_out1),
        .count(count), .full(full), .empty(empty)
    );

    // Instruction word derived from its PC so data and address can be cross-checked
    function automatic logic [31:0] dw(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic we1, input logic we2, input logic [31:0] pc1,
                         input logic [31:0] pc2, input logic re1, input logic re2);
        write_en1      = we1;
        write_en2      = we2;
        write_address1 = pc1;
        write_address2 = pc2;
        write_data1    = dw(pc1);
        write_data2    = dw(pc2);
        read_en1       = re1;
        read_en2       = re2;
        flush          = 1'b0;
        flush_keep_slot = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_valid1", 64'(valid_out1), 64'd0);
        chk("rst_valid2", 64'(valid_out2), 64'd0);
        chk("rst_data1", 64'(data_out1), 64'd0);
        chk("rst_addr1", 64'(address_out1), 64'd0);
        chk("rst_slot", 64'(delay_slot_out1), 64'd0);

        // Fill with 8 write pairs, no reads
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'(32'h100 + 8 * i), 32'(32'h104 + 8 * i), 1'b0, 1'b0);
            tick();
        end
        idle();
        settle();
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_addr1", 64'(address_out1), 64'h100);
        chk("fill_data1", 64'(data_out1), 64'(dw(32'h100)));
        chk("fill_addr2", 64'(address_out2), 64'h104);

        // Write when full is dropped
        drive(1'b1, 1'b1, 32'h200, 32'h204, 1'b0, 1'b0);
        tick();
        idle();
        settle();
        chk("drop_count", 64'(count), 64'd16);
        chk("drop_head", 64'(address_out1), 64'h100);

        // Drain two per cycle in PC order
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
            settle();
            chk("drain_addr1", 64'(address_out1), 64'(32'h100 + 8 * i));
            chk("drain_addr2", 64'(address_out2), 64'(32'h104 + 8 * i));
            tick();
        end
        idle();
        settle();
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_count", 64'(count), 64'd0);

        // count=1 over-read plus single write keeps count at 1
        drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h304, 32'h0, 1'b1, 1'b1);
        settle();
        chk("ovr_valid2", 64'(valid_out2), 64'd0);
        chk("ovr_addr1", 64'(address_out1), 64'h300);
        tick();
        idle();
        settle();
        chk("ovr_count", 64'(count), 64'd1);
        chk("ovr_next", 64'(address_out1), 64'h304);

        // Stream 20 entries across the pointer wrap while reading two per cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 32'(32'h400 + 8 * i), 32'(32'h404 + 8 * i), 1'b1, 1'b1);
            settle();
            if (i == 0) begin
                chk("wrap_first", 64'(address_out1), 64'h304);
                chk("wrap_first_v2", 64'(valid_out2), 64'd0);
            end else begin
                chk("wrap_addr1", 64'(address_out1), 64'(32'h400 + 8 * (i - 1)));
                chk("wrap_addr2", 64'(address_out2), 64'(32'h404 + 8 * (i - 1)));
                chk("wrap_data2", 64'(data_out2), 64'(dw(32'(32'h404 + 8 * (i - 1)))));
                chk("wrap_count", 64'(count), 64'd2);
            end
            tick();
        end
        idle();
        settle();
        chk("wrap_tail_cnt", 64'(count), 64'd2);
        chk("wrap_tail1", 64'(address_out1), 64'h448);
        chk("wrap_tail2", 64'(address_out2), 64'h44C);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        idle();
        settle();
        chk("wrap_empty", 64'(empty), 64'd1);

        // A,B,C stored; flush keeping slot captures B
        drive(1'b1, 1'b1, 32'h500, 32'h504, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h508, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        flush = 1'b1;
        flush_keep_slot = 1'b1;
        tick();
        idle();
        settle();
        chk("slot_addr1", 64'(address_out1), 64'h504);
        chk("slot_data1", 64'(data_out1), 64'(dw(32'h504)));
        chk("slot_flag", 64'(delay_slot_out1), 64'd1);
        chk("slot_valid1", 64'(valid_out1), 64'd1);
        chk("slot_valid2", 64'(valid_out2), 64'd0);
        chk("slot_count", 64'(count), 64'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        settle();
        chk("slot_rd_flag", 64'(delay_slot_out1), 64'd0);
        chk("slot_rd_valid", 64'(valid_out1), 64'd0);
        chk("slot_rd_empty", 64'(empty), 64'd1);
        drive(1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        settle();
        chk("post_slot_addr", 64'(address_out1), 64'h600);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // count=1 flush with keep and no write waits for the slot
        drive(1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        flush = 1'b1;
        flush_keep_slot = 1'b1;
        tick();
        idle();
        settle();
        chk("wait_valid1", 64'(valid_out1), 64'd0);
        chk("wait_valid2", 64'(valid_out2), 64'd0);
        chk("wait_flag", 64'(delay_slot_out1), 64'd0);
        chk("wait_count", 64'(count), 64'd0);
        drive(1'b1, 1'b1, 32'h800, 32'h804, 1'b1, 1'b0);
        settle();
        chk("wait_nobyp", 64'(valid_out1), 64'd0);
        tick();
        idle();
        settle();
        chk("cap_addr1", 64'(address_out1), 64'h800);
        chk("cap_flag", 64'(delay_slot_out1), 64'd1);
        chk("cap_valid2", 64'(valid_out2), 64'd0);
        chk("cap_count", 64'(count), 64'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        idle();
        settle();
        chk("cap_next_addr", 64'(address_out1), 64'h804);
        chk("cap_next_flag", 64'(delay_slot_out1), 64'd0);
        chk("cap_next_cnt", 64'(count), 64'd1);

        // Plain flush discards contents and same-cycle traffic
        drive(1'b1, 1'b1, 32'hA00, 32'hA04, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        idle();
        settle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid1", 64'(valid_out1), 64'd0);

        // Capacity boundary at DEPTH-1: pair dropped, single accepted
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 32'(32'hB00 + 8 * i), 32'(32'hB04 + 8 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 32'hB38, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        settle();
        chk("b15_count", 64'(count), 64'd15);
        chk("b15_full", 64'(full), 64'd1);
        drive(1'b1, 1'b1, 32'hBF0, 32'hBF4, 1'b0, 1'b0);
        tick();
        idle();
        settle();
        chk("b15_drop", 64'(count), 64'd15);
        drive(1'b1, 1'b0, 32'hC00, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        settle();
        chk("b15_rw", 64'(count), 64'd15);
        chk("b15_head1", 64'(address_out1), 64'hB04);
        chk("b15_head2", 64'(address_out2), 64'hB08);
        drive(1'b1, 1'b0, 32'hC04, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        settle();
        chk("b16_count", 64'(count), 64'd16);
        flush = 1'b1;
        tick();
        idle();
        settle();
        chk("b_clear", 64'(empty), 64'd1);

        // Same-cycle write pair and read pair on an empty queue
        drive(1'b1, 1'b1, 32'h900, 32'h904, 1'b1, 1'b1);
        settle();
`ifdef IFIFO_BYPASS_EN
        chk("byp_valid1", 64'(valid_out1), 64'd1);
        chk("byp_valid2", 64'(valid_out2), 64'd1);
        chk("byp_addr1", 64'(address_out1), 64'h900);
        chk("byp_addr2", 64'(address_out2), 64'h904);
        tick();
        idle();
        settle();
        chk("byp_count", 64'(count), 64'd0);
`else
        chk("nobyp_valid1", 64'(valid_out1), 64'd0);
        chk("nobyp_addr1", 64'(address_out1), 64'd0);
        tick();
        idle();
        settle();
        chk("nobyp_count", 64'(count), 64'd2);
        chk("nobyp_addr", 64'(address_out1), 64'h900);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
